// File: rtl/bster_axi_ram.sv
// bster_axi_ram: AXI4 slave backed by a single-clock word RAM.
// Independent write (AW/W/B) and read (AR/R) state machines share the array;
// a read and a write of the same word in one cycle returns the old data.
// Optional build macro BSTER_AXI_RAM_SLVERR_EN: bursts with a narrow size or
// WRAP type are answered with SLVERR, write nothing and read back zeros.
`timescale 1ns/1ps
module bster_axi_ram #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH/8,
  parameter int RAM_ID_WIDTH   = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_awid,
  input  logic [RAM_ADDR_WIDTH-1:0] ram_axi_awaddr,
  input  logic [7:0]                ram_axi_awlen,
  input  logic [2:0]                ram_axi_awsize,
  input  logic [1:0]                ram_axi_awburst,
  input  logic                      ram_axi_awlock,
  input  logic [3:0]                ram_axi_awcache,
  input  logic [2:0]                ram_axi_awprot,
  input  logic                      ram_axi_awvalid,
  output logic                      ram_axi_awready,
  input  logic [RAM_DATA_WIDTH-1:0] ram_axi_wdata,
  input  logic [RAM_STRB_WIDTH-1:0] ram_axi_wstrb,
  input  logic                      ram_axi_wlast,
  input  logic                      ram_axi_wvalid,
  output logic                      ram_axi_wready,
  output logic [RAM_ID_WIDTH-1:0]   ram_axi_bid,
  output logic [1:0]                ram_axi_bresp,
  output logic                      ram_axi_bvalid,
  input  logic                      ram_axi_bready,
  input  logic [RAM_ID_WIDTH-1:0]   ram_axi_arid,
  input  logic [RAM_ADDR_WIDTH-1:0] ram_axi_araddr,
  input  logic [7:0]                ram_axi_arlen,
  input  logic [2:0]                ram_axi_arsize,
  input  logic [1:0]                ram_axi_arburst,
  input  logic                      ram_axi_arlock,
  input  logic [3:0]                ram_axi_arcache,
  input  logic [2:0]                ram_axi_arprot,
  input  logic                      ram_axi_arvalid,
  output logic                      ram_axi_arready,
  output logic [RAM_ID_WIDTH-1:0]   ram_axi_rid,
  output logic [RAM_DATA_WIDTH-1:0] ram_axi_rdata,
  output logic [1:0]                ram_axi_rresp,
  output logic                      ram_axi_rlast,
  output logic                      ram_axi_rvalid,
  input  logic                      ram_axi_rready
);

  localparam int ADDR_LSB   = $clog2(RAM_STRB_WIDTH);
  localparam int WORD_WIDTH = RAM_ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH      = 2**WORD_WIDTH;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t                w_state, w_next;
  logic [RAM_ID_WIDTH-1:0] w_id;
  logic [WORD_WIDTH-1:0]   w_index;
  logic [1:0]              w_burst;
  logic                    w_err;

  r_state_t                  r_state, r_next;
  logic [RAM_ID_WIDTH-1:0]   r_id;
  logic [WORD_WIDTH-1:0]     r_index;
  logic [1:0]                r_burst;
  logic [7:0]                r_len;
  logic [7:0]                r_cnt;
  logic                      r_err;
  logic [RAM_DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic aw_err, ar_err;
  logic r_last_beat;
  logic unused_inputs;

  assign aw_hs       = (w_state == W_IDLE) && ram_axi_awvalid;
  assign w_hs        = (w_state == W_DATA) && ram_axi_wvalid;
  assign ar_hs       = (r_state == R_IDLE) && ram_axi_arvalid;
  assign r_hs        = (r_state == R_DATA) && ram_axi_rready;
  assign r_last_beat = (r_cnt == r_len);

`ifdef BSTER_AXI_RAM_SLVERR_EN
  localparam logic [2:0] FULL_SIZE = 3'(ADDR_LSB);
  assign aw_err = (ram_axi_awsize != FULL_SIZE) || (ram_axi_awburst == 2'b10);
  assign ar_err = (ram_axi_arsize != FULL_SIZE) || (ram_axi_arburst == 2'b10);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // Side-band attributes carry no meaning for a plain RAM.
  assign unused_inputs = ^{ram_axi_awlock, ram_axi_awcache, ram_axi_awprot,
                           ram_axi_arlock, ram_axi_arcache, ram_axi_arprot,
                           ram_axi_awsize, ram_axi_arsize, ram_axi_awlen,
                           ram_axi_awaddr, ram_axi_araddr};

  // Write state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  // Write next-state and channel handshake outputs.
  always_comb begin
    w_next          = w_state;
    ram_axi_awready = 1'b0;
    ram_axi_wready  = 1'b0;
    ram_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        ram_axi_awready = 1'b1;
        if (ram_axi_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        ram_axi_wready = 1'b1;
        if (ram_axi_wvalid && ram_axi_wlast) w_next = W_RESP;
      end
      W_RESP: begin
        ram_axi_bvalid = 1'b1;
        if (ram_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst context: latched on AW, index stepped on every W beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_id    <= '0;
      w_index <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= ram_axi_awid;
      w_index <= ram_axi_awaddr[RAM_ADDR_WIDTH-1:ADDR_LSB];
      w_burst <= ram_axi_awburst;
      w_err   <= aw_err;
    end else if (w_hs && (w_burst != BURST_FIXED)) begin
      w_index <= w_index + 1'b1;
    end
  end

  assign ram_axi_bid   = w_id;
  assign ram_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;

  // Byte-lane writes into the array; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_err) begin
      for (int i = 0; i < RAM_STRB_WIDTH; i++) begin
        if (ram_axi_wstrb[i]) mem[w_index][8*i +: 8] <= ram_axi_wdata[8*i +: 8];
      end
    end
  end

  // Read state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  // Read next-state and channel handshake outputs.
  always_comb begin
    r_next          = r_state;
    ram_axi_arready = 1'b0;
    ram_axi_rvalid  = 1'b0;
    ram_axi_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ram_axi_arready = 1'b1;
        if (ram_axi_arvalid) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        ram_axi_rvalid = 1'b1;
        ram_axi_rlast  = r_last_beat;
        if (ram_axi_rready) r_next = r_last_beat ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst context: latched on AR, advanced after each accepted beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_id    <= '0;
      r_index <= '0;
      r_burst <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= ram_axi_arid;
      r_index <= ram_axi_araddr[RAM_ADDR_WIDTH-1:ADDR_LSB];
      r_burst <= ram_axi_arburst;
      r_len   <= ram_axi_arlen;
      r_cnt   <= '0;
      r_err   <= ar_err;
    end else if (r_hs && !r_last_beat) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_burst != BURST_FIXED) r_index <= r_index + 1'b1;
    end
  end

  // Registered array read; the value is held while the beat waits for rready.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                  rdata_q <= '0;
    else if (r_state == R_FETCH) rdata_q <= r_err ? '0 : mem[r_index];
  end

  assign ram_axi_rid   = r_id;
  assign ram_axi_rdata = rdata_q;
  assign ram_axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_bster_axi_ram.sv
// tb_bster_axi_ram: randomized scoreboard bench for bster_axi_ram.
// A byte-addressed reference memory predicts every B and R beat; a negedge
// monitor pops predictions as the DUT hands out responses.
`timescale 1ns/1ps
module tb_bster_axi_ram;

  logic        aclk;
  logic        areset;
  logic [7:0]  awid;
  logic [11:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  arid;
  logic [11:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  bster_axi_ram dut (
    .aclk(aclk), .areset(areset),
    .ram_axi_awid(awid), .ram_axi_awaddr(awaddr), .ram_axi_awlen(awlen),
    .ram_axi_awsize(awsize), .ram_axi_awburst(awburst), .ram_axi_awlock(awlock),
    .ram_axi_awcache(awcache), .ram_axi_awprot(awprot), .ram_axi_awvalid(awvalid),
    .ram_axi_awready(awready),
    .ram_axi_wdata(wdata), .ram_axi_wstrb(wstrb), .ram_axi_wlast(wlast),
    .ram_axi_wvalid(wvalid), .ram_axi_wready(wready),
    .ram_axi_bid(bid), .ram_axi_bresp(bresp), .ram_axi_bvalid(bvalid),
    .ram_axi_bready(bready),
    .ram_axi_arid(arid), .ram_axi_araddr(araddr), .ram_axi_arlen(arlen),
    .ram_axi_arsize(arsize), .ram_axi_arburst(arburst), .ram_axi_arlock(arlock),
    .ram_axi_arcache(arcache), .ram_axi_arprot(arprot), .ram_axi_arvalid(arvalid),
    .ram_axi_arready(arready),
    .ram_axi_rid(rid), .ram_axi_rdata(rdata), .ram_axi_rresp(rresp),
    .ram_axi_rlast(rlast), .ram_axi_rvalid(rvalid), .ram_axi_rready(rready)
  );

  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];

  logic [7:0]  model_bytes [4096];
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];

  int n_compared;
  int n_mismatched;
  bit stall_r;

  logic        prev_r_hold, prev_b_hold, prev_rlast;
  logic [31:0] prev_rdata;
  logic [7:0]  prev_rid, prev_bid;
  logic [1:0]  prev_bresp;

  // 100 MHz clock.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop in case the bench itself wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit burst_err(input logic [2:0] size, input logic [1:0] burst);
`ifdef BSTER_AXI_RAM_SLVERR_EN
    return (size != 3'd2) || (burst == 2'b10);
`else
    return (size === 3'bxxx) && (burst === 2'bxx);
`endif
  endfunction

  function automatic logic [31:0] model_word(input int widx);
    int base;
    base = (widx % 1024) * 4;
    return {model_bytes[base+3], model_bytes[base+2], model_bytes[base+1], model_bytes[base]};
  endfunction

  task automatic model_write(input int widx, input logic [31:0] data, input logic [3:0] strb);
    int base;
    base = (widx % 1024) * 4;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_bytes[base+b] = data[8*b +: 8];
  endtask

  // Ready generators for the response channels.
  initial begin
    rready = 1'b0;
    bready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      rready = stall_r ? 1'b0 : ($urandom_range(0, 3) != 0);
      bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops predictions on every handshake and checks that a stalled
  // response does not change while it waits.
  always @(negedge aclk) begin
    if (areset) begin
      prev_r_hold = 1'b0;
      prev_b_hold = 1'b0;
    end else begin
      if (prev_r_hold) begin
        check_output("r_hold_valid", 64'(rvalid), 64'd1);
        check_output("r_hold_data", 64'(rdata), 64'(prev_rdata));
        check_output("r_hold_last", 64'(rlast), 64'(prev_rlast));
        check_output("r_hold_id", 64'(rid), 64'(prev_rid));
      end
      if (prev_b_hold) begin
        check_output("b_hold_valid", 64'(bvalid), 64'd1);
        check_output("b_hold_id", 64'(bid), 64'(prev_bid));
        check_output("b_hold_resp", 64'(bresp), 64'(prev_bresp));
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) check_output("r_unexpected", 64'd1, 64'd0);
        else begin
          r_exp_t e;
          e = r_q.pop_front();
          check_output("r_id", 64'(rid), 64'(e.id));
          check_output("r_data", 64'(rdata), 64'(e.data));
          check_output("r_resp", 64'(rresp), 64'(e.resp));
          check_output("r_last", 64'(rlast), 64'(e.last));
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check_output("b_unexpected", 64'd1, 64'd0);
        else begin
          b_exp_t e;
          e = b_q.pop_front();
          check_output("b_id", 64'(bid), 64'(e.id));
          check_output("b_resp", 64'(bresp), 64'(e.resp));
        end
      end
      prev_r_hold = rvalid && !rready;
      prev_rdata  = rdata;
      prev_rlast  = rlast;
      prev_rid    = rid;
      prev_b_hold = bvalid && !bready;
      prev_bid    = bid;
      prev_bresp  = bresp;
    end
  end

  // Write burst from wr_data/wr_strb; abort_after >= 0 stops after that many beats.
  task automatic do_write(input logic [7:0] id, input int addr, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int abort_after);
    bit ok;
    bit err;
    int widx;
    err     = burst_err(size, burst);
    awid    = id;
    awaddr  = 12'(addr);
    awlen   = 8'(len);
    awsize  = size;
    awburst = burst;
    awlock  = 1'($urandom);
    awcache = 4'($urandom);
    awprot  = 3'($urandom);
    awvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge aclk);
      if (awready) begin ok = 1'b1; break; end
    end
    if (!ok) check_output("aw_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
    widx = (addr / 4) % 1024;
    for (int beat = 0; beat <= len; beat++) begin
      if (abort_after >= 0 && beat == abort_after) return;
      wdata  = wr_data[beat];
      wstrb  = wr_strb[beat];
      wlast  = (beat == len);
      wvalid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge aclk);
        if (wready) begin ok = 1'b1; break; end
      end
      if (!ok) check_output("w_timeout", 64'd0, 64'd1);
      if (!err) model_write(widx, wr_data[beat], wr_strb[beat]);
      if (burst != 2'b00) widx = (widx + 1) % 1024;
      @(posedge aclk);
      #1;
      wvalid = 1'b0;
      wlast  = 1'b0;
    end
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
  endtask

  // Read burst: predictions queued up front, first-beat latency checked,
  // then the task waits until every beat has been consumed.
  task automatic do_read(input logic [7:0] id, input int addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size);
    bit ok;
    bit err;
    int widx;
    int lat;
    err  = burst_err(size, burst);
    widx = (addr / 4) % 1024;
    for (int beat = 0; beat <= len; beat++) begin
      r_q.push_back('{id: id, data: err ? 32'd0 : model_word(widx),
                      resp: err ? 2'b10 : 2'b00, last: (beat == len)});
      if (burst != 2'b00) widx = (widx + 1) % 1024;
    end
    arid    = id;
    araddr  = 12'(addr);
    arlen   = 8'(len);
    arsize  = size;
    arburst = burst;
    arlock  = 1'($urandom);
    arcache = 4'($urandom);
    arprot  = 3'($urandom);
    arvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge aclk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) check_output("ar_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
    lat = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge aclk);
      lat++;
      if (rvalid) break;
    end
    check_output("r_first_latency", 64'(lat), 64'd2);
    @(posedge aclk);
    #1;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (r_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge aclk);
      #1;
    end
    if (!ok) begin
      check_output("r_drain_timeout", 64'(r_q.size()), 64'd0);
      r_q.delete();
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (b_q.size() == 0 && r_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge aclk);
      #1;
    end
    if (!ok) begin
      check_output("idle_timeout", 64'(b_q.size() + r_q.size()), 64'd0);
      b_q.delete();
      r_q.delete();
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_awready", 64'(awready), 64'd1);
    check_output("rst_arready", 64'(arready), 64'd1);
    check_output("rst_wready", 64'(wready), 64'd0);
    check_output("rst_bvalid", 64'(bvalid), 64'd0);
    check_output("rst_rvalid", 64'(rvalid), 64'd0);
    check_output("rst_rlast", 64'(rlast), 64'd0);
    check_output("rst_bid", 64'(bid), 64'd0);
    check_output("rst_rid", 64'(rid), 64'd0);
    check_output("rst_rdata", 64'(rdata), 64'd0);
    check_output("rst_bresp", 64'(bresp), 64'd0);
    check_output("rst_rresp", 64'(rresp), 64'd0);
  endtask

  task automatic fill_random(input int beats);
    for (int i = 0; i < beats; i++) begin
      wr_data[i] = $urandom;
      wr_strb[i] = 4'hF;
    end
  endtask

  task automatic apply_stimulus();
    // Reset state.
    {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid} = '0;
    {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid} = '0;
    stall_r = 1'b0;
    areset  = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs();
    @(posedge aclk);
    #1 areset = 1'b0;

    // Give words 0..127 known contents.
    fill_random(64);
    do_write(8'h01, 12'h000, 63, 2'b01, 3'd2, -1);
    fill_random(64);
    do_write(8'h02, 12'h100, 63, 2'b01, 3'd2, -1);

    // Single-beat write and read-back.
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    do_write(8'h5A, 12'h010, 0, 2'b01, 3'd2, -1);
    do_read(8'hA5, 12'h010, 0, 2'b01, 3'd2);

    // Four-beat INCR burst.
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    do_write(8'h11, 12'h100, 3, 2'b01, 3'd2, -1);
    do_read(8'h12, 12'h100, 3, 2'b01, 3'd2);

    // Byte strobes merge into existing data.
    wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
    do_write(8'h21, 12'h040, 0, 2'b01, 3'd2, -1);
    wr_data[0] = 32'h00000000; wr_strb[0] = 4'h5;
    do_write(8'h22, 12'h040, 0, 2'b01, 3'd2, -1);
    do_read(8'h23, 12'h040, 0, 2'b01, 3'd2);

    // FIXED burst keeps hitting one word; the neighbour is untouched.
    wr_data[0] = 32'd7; wr_data[1] = 32'd8; wr_data[2] = 32'd9;
    for (int i = 0; i < 3; i++) wr_strb[i] = 4'hF;
    do_write(8'h31, 12'h020, 2, 2'b00, 3'd2, -1);
    do_read(8'h32, 12'h020, 0, 2'b01, 3'd2);
    do_read(8'h33, 12'h024, 0, 2'b01, 3'd2);
    do_read(8'h34, 12'h020, 3, 2'b00, 3'd2);

    // Burst running past the top of memory wraps to word 0.
    fill_random(2);
    do_write(8'h41, 12'hFFC, 1, 2'b01, 3'd2, -1);
    do_read(8'h42, 12'hFFC, 1, 2'b01, 3'd2);

    // WRAP type and narrow size bursts.
    fill_random(4);
    do_write(8'h51, 12'h080, 3, 2'b10, 3'd2, -1);
    do_read(8'h52, 12'h080, 3, 2'b10, 3'd2);
    do_read(8'h53, 12'h080, 3, 2'b01, 3'd2);
    fill_random(2);
    do_write(8'h54, 12'h0C0, 1, 2'b01, 3'd1, -1);
    do_read(8'h55, 12'h0C0, 1, 2'b01, 3'd2);
    do_read(8'h56, 12'h0C0, 1, 2'b01, 3'd1);
    wait_idle();

    // Stalled read burst with a write burst completing alongside it.
    stall_r = 1'b1;
    fill_random(4);
    fork
      do_read(8'h61, 12'h100, 3, 2'b01, 3'd2);
      begin
        repeat (2) @(posedge aclk);
        #1;
        do_write(8'h62, 12'h000, 3, 2'b01, 3'd2, -1);
        repeat (5) @(posedge aclk);
        #1 stall_r = 1'b0;
      end
    join
    wait_idle();

    // Random traffic inside words 0..63.
    for (int n = 0; n < 40; n++) begin
      int len, sw, bsel;
      logic [1:0] burst;
      logic [2:0] size;
      len   = $urandom_range(0, 7);
      sw    = $urandom_range(0, 56);
      bsel  = $urandom_range(0, 5);
      burst = (bsel < 2) ? 2'b00 : ((bsel < 5) ? 2'b01 : 2'b10);
      size  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wr_data[i] = $urandom;
          wr_strb[i] = 4'($urandom);
        end
        do_write(8'($urandom), sw * 4, len, burst, size, -1);
      end else begin
        do_read(8'($urandom), sw * 4, len, burst, size);
      end
    end
    wait_idle();

    // Reset in the middle of a write burst: two beats land, no response.
    fill_random(4);
    do_write(8'h71, 12'h180, 3, 2'b01, 3'd2, -1);
    do_read(8'h72, 12'h180, 0, 2'b01, 3'd2);
    wait_idle();
    fill_random(4);
    do_write(8'h73, 12'h180, 3, 2'b01, 3'd2, 2);
    areset = 1'b1;
    @(negedge aclk);
    check_reset_outputs();
    @(posedge aclk);
    #1 areset = 1'b0;
    do_read(8'h74, 12'h180, 3, 2'b01, 3'd2);
    wait_idle();

    repeat (5) @(posedge aclk);
    check_output("b_queue_empty", 64'(b_q.size()), 64'd0);
    check_output("r_queue_empty", 64'(r_q.size()), 64'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
